// File: rtl/ofdm_demapper_sequencer_pkg.sv
// Shared types and constants for the OFDM demapper frame sequencer.
package ofdm_demapper_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_CLR,
    ST_WR_MOD,
    ST_WR_SCL,
    ST_RUN
  } state_t;

  localparam int unsigned CMD_W        = 48;
  localparam int unsigned CMD_NSYM_LSB = 32;
  localparam int unsigned CMD_SCL_LSB  = 16;
  localparam int unsigned CMD_ORD_LSB  = 0;

  localparam logic [3:0] BPSK  = 4'd1;
  localparam logic [3:0] QPSK  = 4'd2;
  localparam logic [3:0] QAM16 = 4'd4;
  localparam logic [3:0] QAM64 = 4'd6;

  function automatic logic order_legal(input logic [3:0] order);
    return (order == BPSK) || (order == QPSK) || (order == QAM16) || (order == QAM64);
  endfunction

endpackage

// File: rtl/ofdm_demapper_sequencer_if.sv
// Command and sample-stream handshakes between the environment and the sequencer.
interface ofdm_demapper_sequencer_if;

  logic [47:0] cmd_tdata;
  logic        cmd_tvalid;
  logic        cmd_tready;

  logic [31:0] s_tdata;
  logic        s_tlast;
  logic        s_tvalid;
  logic        s_tready;

  logic [31:0] m_tdata;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready;

  // Environment side: issues commands, sources samples, sinks the gated stream.
  modport master (
    output cmd_tdata, cmd_tvalid, s_tdata, s_tlast, s_tvalid, m_tready,
    input  cmd_tready, s_tready, m_tdata, m_tlast, m_tvalid
  );

  // Sequencer side.
  modport slave (
    input  cmd_tdata, cmd_tvalid, s_tdata, s_tlast, s_tvalid, m_tready,
    output cmd_tready, s_tready, m_tdata, m_tlast, m_tvalid
  );

endinterface

// File: rtl/ofdm_demapper_sequencer.sv
// Per-frame demapper controller: drains, clears and reconfigures the demapper,
// then gates exactly the commanded number of OFDM symbols through.
module ofdm_demapper_sequencer
  import ofdm_demapper_seq_pkg::*;
#(
  parameter logic [7:0]  SR_MODULATION_ORDER = 8'd0,
  parameter logic [7:0]  SR_SCALING          = 8'd1,
  parameter int unsigned DRAIN_CYCLES        = 16,
  parameter int unsigned SYM_CNT_W           = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  ofdm_demapper_sequencer_if.slave bus,
  output logic                 set_stb,
  output logic [7:0]           set_addr,
  output logic [31:0]          set_data,
  output logic                 demap_clear,
  output logic                 busy,
  output logic                 cmd_err,
  output logic [SYM_CNT_W-1:0] sym_count
);

  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  state_t state_q, state_d;

  logic [DRAIN_W-1:0] drain_cnt_q;
  logic [3:0]         order_q;
  logic [15:0]        scaling_q;
  logic [15:0]        sym_left_q;

  logic [3:0]  cmd_order;
  logic [15:0] cmd_scaling;
  logic [15:0] cmd_nsym;
  logic        cmd_fire;
  logic        cmd_ok;
  logic        last_fire;
  logic        frame_done;
  logic        unused_cmd_bits;

  assign cmd_order   = bus.cmd_tdata[CMD_ORD_LSB +: 4];
  assign cmd_scaling = bus.cmd_tdata[CMD_SCL_LSB +: 16];
  assign cmd_nsym    = bus.cmd_tdata[CMD_NSYM_LSB +: 16];
  assign unused_cmd_bits = ^bus.cmd_tdata[15:4];

  assign cmd_fire   = bus.cmd_tvalid && bus.cmd_tready;
  assign cmd_ok     = order_legal(cmd_order) && (cmd_nsym != '0);
  assign last_fire  = bus.s_tvalid && bus.s_tready && bus.s_tlast;
  // Remaining-symbol down-counter keeps frame end independent of SYM_CNT_W wrap.
  assign frame_done = last_fire && (sym_left_q == 16'd1);

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (cmd_fire && cmd_ok) state_d = ST_DRAIN;
      ST_DRAIN:  if (drain_cnt_q == '0) state_d = ST_CLR;
      ST_CLR:    state_d = ST_WR_MOD;
      ST_WR_MOD: state_d = ST_WR_SCL;
      ST_WR_SCL: state_d = ST_RUN;
      ST_RUN:    if (frame_done) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_tready = (state_q == ST_IDLE);
    busy           = (state_q != ST_IDLE);
    bus.m_tdata    = bus.s_tdata;
    bus.m_tlast    = bus.s_tlast;
    bus.m_tvalid   = (state_q == ST_RUN) && bus.s_tvalid;
    bus.s_tready   = (state_q == ST_RUN) && bus.m_tready;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      set_stb     <= 1'b0;
      set_addr    <= '0;
      set_data    <= '0;
      demap_clear <= 1'b0;
      cmd_err     <= 1'b0;
      sym_count   <= '0;
      drain_cnt_q <= '0;
      order_q     <= '0;
      scaling_q   <= '0;
      sym_left_q  <= '0;
    end else if (clear) begin
      set_stb     <= 1'b0;
      set_addr    <= '0;
      set_data    <= '0;
      demap_clear <= 1'b1;
      cmd_err     <= 1'b0;
      sym_count   <= '0;
      drain_cnt_q <= '0;
      sym_left_q  <= '0;
    end else begin
      cmd_err     <= cmd_fire && !order_legal(cmd_order);
      demap_clear <= (state_d == ST_CLR);

      unique case (state_d)
        ST_WR_MOD: begin
          set_stb  <= 1'b1;
          set_addr <= SR_MODULATION_ORDER;
          set_data <= {28'b0, order_q};
        end
        ST_WR_SCL: begin
          set_stb  <= 1'b1;
          set_addr <= SR_SCALING;
          set_data <= {16'b0, scaling_q};
        end
        default: begin
          set_stb  <= 1'b0;
          set_addr <= '0;
          set_data <= '0;
        end
      endcase

      if (state_q == ST_IDLE && cmd_fire && cmd_ok) begin
        order_q     <= cmd_order;
        scaling_q   <= cmd_scaling;
        sym_left_q  <= cmd_nsym;
        drain_cnt_q <= DRAIN_W'(DRAIN_CYCLES - 1);
      end else if (state_q == ST_DRAIN && drain_cnt_q != '0) begin
        drain_cnt_q <= drain_cnt_q - DRAIN_W'(1);
      end

      if (state_q == ST_WR_SCL) begin
        sym_count <= '0;
      end else if (last_fire) begin
        sym_count  <= sym_count + SYM_CNT_W'(1);
        sym_left_q <= sym_left_q - 16'd1;
      end
    end
  end

endmodule
